// File: rtl/lattice_pkg.sv
// Shared types and helpers for the lattice core results path.
package lattice_pkg;
  localparam int DEF_IDX_W   = 2;
  localparam int DEF_STAMP_W = 32;

  typedef struct packed {
    logic [DEF_IDX_W-1:0]   index;
    logic [DEF_STAMP_W-1:0] stamp;
  } result_t;

  function automatic int IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/result_fifo.sv
// Show-ahead result queue; pointers carry a wrap bit so every entry is usable.
module result_fifo import lattice_pkg::*; #(
  parameter int  DEPTH   = 8,
  parameter type entry_t = result_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t dout,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);

  entry_t       mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Storage is not reset, so the head reads as zero whenever nothing is queued.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/lattice_result_collector.sv
// Collects per-core success pulses, stamps them with the job cycle and queues
// them one per cycle, lowest core index first.
module lattice_result_collector import lattice_pkg::*; #(
  parameter int NUM_CORES   = 4,
  parameter int STAMP_WIDTH = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [NUM_CORES-1:0]          success_i,
  output logic                          result_valid_o,
  input  logic                          result_ready_i,
  output logic [IDX_W(NUM_CORES)-1:0]   result_index_o,
  output logic [STAMP_WIDTH-1:0]        result_stamp_o,
  output logic [COUNT_WIDTH-1:0]        found_count_o,
  output logic [COUNT_WIDTH-1:0]        dropped_count_o
);
  localparam int IW = IDX_W(NUM_CORES);
  localparam int DW = $clog2(NUM_CORES + 1);
  localparam int SW = ((COUNT_WIDTH > DW) ? COUNT_WIDTH : DW) + 1;

  typedef struct packed {
    logic [IW-1:0]          index;
    logic [STAMP_WIDTH-1:0] stamp;
  } entry_t;

  logic [STAMP_WIDTH-1:0]                cnt;
  logic [NUM_CORES-1:0]                  pend;
  logic [NUM_CORES-1:0][STAMP_WIDTH-1:0] stamp_q;
  logic [NUM_CORES-1:0]                  gnt_vec;
  logic [IW-1:0]                         gidx;
  logic                                  any_pend, grant, pop, full, empty;
  logic [DW-1:0]                         drops;
  logic [SW-1:0]                         dsum;
  entry_t                                wr_ent, head;

  assign pop = result_valid_o & result_ready_i;

  always_comb begin
    gidx     = '0;
    any_pend = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (pend[i]) begin
        gidx     = IW'(i);
        any_pend = 1'b1;
      end
    end
  end

  // A pop this cycle frees the slot the grant needs even when full.
  assign grant   = any_pend && (!full || pop) && !start_i;
  assign gnt_vec = grant ? (NUM_CORES'(1) << gidx) : '0;

  always_comb begin
    drops = '0;
    for (int i = 0; i < NUM_CORES; i++)
      drops = drops + DW'(success_i[i] & pend[i] & ~gnt_vec[i]);
  end
  assign dsum = SW'(dropped_count_o) + SW'(drops);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend    <= '0;
      stamp_q <= '0;
    end else if (start_i) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (success_i[i] && (!pend[i] || gnt_vec[i])) begin
          pend[i]    <= 1'b1;
          stamp_q[i] <= cnt;
        end else if (gnt_vec[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt             <= '0;
      found_count_o   <= '0;
      dropped_count_o <= '0;
    end else if (start_i) begin
      // The start cycle itself is job cycle 0.
      cnt             <= STAMP_WIDTH'(1);
      found_count_o   <= '0;
      dropped_count_o <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (grant && found_count_o != '1) found_count_o <= found_count_o + 1'b1;
      dropped_count_o <= (dsum > SW'({COUNT_WIDTH{1'b1}})) ? '1 : dsum[COUNT_WIDTH-1:0];
    end
  end

  assign wr_ent.index = gidx;
  assign wr_ent.stamp = stamp_q[gidx];

  result_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start_i),
    .push  (grant),
    .din   (wr_ent),
    .pop   (pop & ~start_i),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign result_valid_o = ~empty;
  assign result_index_o = head.index;
  assign result_stamp_o = head.stamp;
endmodule

// File: tb/tb_lattice_result_collector.sv
// Directed scoreboard bench for lattice_result_collector.
module tb_lattice_result_collector;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  success = '0;
  logic        ready = 1'b0;
  logic        valid;
  logic [1:0]  idx;
  logic [31:0] stamp;
  logic [15:0] found, dropped;

  logic        start2 = 1'b0;
  logic [3:0]  success2 = '0;
  logic        ready2 = 1'b0;
  logic        valid2;
  logic [1:0]  idx2;
  logic [3:0]  stamp2;
  logic [1:0]  found2, dropped2;

  int n_cmp = 0;
  int n_bad = 0;
  int jc = 0;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] stamp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  lattice_result_collector dut (
    .clk(clk), .rst(rst), .start_i(start), .success_i(success),
    .result_valid_o(valid), .result_ready_i(ready),
    .result_index_o(idx), .result_stamp_o(stamp),
    .found_count_o(found), .dropped_count_o(dropped)
  );

  lattice_result_collector #(.STAMP_WIDTH(4), .FIFO_DEPTH(2), .COUNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .success_i(success2),
    .result_valid_o(valid2), .result_ready_i(ready2),
    .result_index_o(idx2), .result_stamp_o(stamp2),
    .found_count_o(found2), .dropped_count_o(dropped2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    jc++;
  endtask

  task automatic hit(input logic [3:0] v);
    success = v;
    tick();
    success = '0;
  endtask

  task automatic hit2(input logic [3:0] v);
    success2 = v;
    tick();
    success2 = '0;
  endtask

  task automatic start_job();
    start = 1'b1;
    tick();
    start = 1'b0;
    jc = 1;
  endtask

  task automatic push_exp(input int i, input int s);
    exp_t e;
    e.idx   = 2'(i);
    e.stamp = 32'(s);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && valid && ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL sb_unexpected: observed {%0d,%0d} expected nothing", idx, stamp);
      end else begin
        e = sb.pop_front();
        chk("sb_entry", {30'd0, idx, stamp}, {30'd0, e.idx, e.stamp});
      end
    end
  end

  initial begin
    #2 rst = 1'b0;
    tick(); tick();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_index", 64'(idx), 64'd0);
    chk("rst_stamp", 64'(stamp), 64'd0);
    chk("rst_found", 64'(found), 64'd0);
    chk("rst_dropped", 64'(dropped), 64'd0);
    rst = 1'b1;
    tick();

    // Single hit: latency and stamp.
    ready = 1'b1;
    start_job();
    for (int k = 0; k < 10 && jc < 5; k++) tick();
    push_exp(2, 5);
    hit(4'b0100);
    chk("lat_t1_valid", 64'(valid), 64'd0);
    tick();
    chk("lat_t2_valid", 64'(valid), 64'd1);
    tick();
    chk("t1_found", 64'(found), 64'd1);
    chk("t1_dropped", 64'(dropped), 64'd0);

    // Simultaneous hits drain in ascending order.
    start_job();
    for (int k = 0; k < 20 && jc < 10; k++) tick();
    push_exp(0, 10); push_exp(1, 10); push_exp(3, 10);
    hit(4'b1011);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("simul_valid", 64'(valid), 64'd1);
    end
    tick();
    chk("simul_done", 64'(valid), 64'd0);
    chk("simul_found", 64'(found), 64'd3);
    chk("simul_sb", 64'(sb.size()), 64'd0);

    // Backpressure: 8 queued, 1 pending, 3 dropped.
    ready = 1'b0;
    start_job();
    for (int n = 0; n < 12; n++) begin
      if (n < 9) push_exp(0, jc);
      hit(4'b0001);
      tick();
    end
    chk("bp_found_full", 64'(found), 64'd8);
    chk("bp_dropped", 64'(dropped), 64'd3);
    chk("bp_valid", 64'(valid), 64'd1);
    ready = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    chk("bp_found", 64'(found), 64'd9);
    chk("bp_dropped_end", 64'(dropped), 64'd3);
    chk("bp_sb", 64'(sb.size()), 64'd0);

    // Grant/capture collision on core 1.
    start_job();
    tick();
    push_exp(1, jc);
    hit(4'b0010);
    push_exp(1, jc);
    hit(4'b0010);
    for (int k = 0; k < 4; k++) tick();
    chk("coll_dropped", 64'(dropped), 64'd0);
    chk("coll_found", 64'(found), 64'd2);
    chk("coll_sb", 64'(sb.size()), 64'd0);

    // Mid-job start flushes the queue and ignores its own-cycle hit.
    ready = 1'b0;
    start_job();
    hit(4'b0001); hit(4'b0010); hit(4'b0100);
    tick();
    chk("mid_found_pre", 64'(found), 64'd3);
    success = 4'b0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    success = '0;
    jc = 1;
    chk("mid_valid", 64'(valid), 64'd0);
    chk("mid_found", 64'(found), 64'd0);
    chk("mid_dropped", 64'(dropped), 64'd0);
    tick(); tick(); tick();
    chk("mid_no_entry", 64'(valid), 64'd0);
    chk("mid_found_post", 64'(found), 64'd0);

    // Asynchronous reset mid-job.
    hit(4'b0001);
    tick(); tick();
    chk("arst_pre_valid", 64'(valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(valid), 64'd0);
    chk("arst_found", 64'(found), 64'd0);
    chk("arst_stamp", 64'(stamp), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Narrow stamp wraps 15 -> 0.
    ready2 = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    jc = 1;
    for (int k = 0; k < 30 && jc < 15; k++) tick();
    hit2(4'b0001);
    hit2(4'b0001);
    chk("wrap_v1", 64'(valid2), 64'd1);
    chk("wrap_s1", {60'd0, stamp2}, 64'd15);
    tick();
    chk("wrap_v2", 64'(valid2), 64'd1);
    chk("wrap_s2", {60'd0, stamp2}, 64'd0);
    chk("wrap_dropped", 64'(dropped2), 64'd0);

    // Narrow drop counter saturates at all-ones.
    ready2 = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 4; k++) hit2(4'b1111);
    chk("sat_dropped", 64'(dropped2), 64'd3);
    hit2(4'b1111);
    chk("sat_dropped_hold", 64'(dropped2), 64'd3);
    chk("sat_found", 64'(found2), 64'd2);

    chk("final_sb", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
